// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle for mem_access_ctrl.
// The master drives requests (MAR/MDR side); the slave is the sequencer.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int CPU_ADDR_WIDTH = 32
);
  logic                      rd_req;
  logic                      wr_req;
  logic [CPU_ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]     cpu_wdata;
  logic                      busy;
  logic                      ack;
  logic                      err;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output rd_req, wr_req, cpu_addr, cpu_wdata,
    input  busy, ack, err, rdata
  );

  modport slave (
    input  rd_req, wr_req, cpu_addr, cpu_wdata,
    output busy, ack, err, rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencer turning single-cycle CPU read/write requests into the RAM's strobe protocol.
// Optional upper-address range checking is enabled by defining MEM_ACCESS_RANGE_CHECK_EN.
module mem_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_SPACE     = 9,
  parameter int CPU_ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  mem_access_ctrl_if.slave      cpu,
  output logic [ADDR_SPACE-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_datain,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] mem_dataout
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    busy_reg, busy_next;
  logic                    ack_reg, ack_next;
  logic                    err_reg, err_next;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic [ADDR_SPACE-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0]   mem_datain_reg, mem_datain_next;
  logic                    mem_read_reg, mem_read_next;
  logic                    mem_write_reg, mem_write_next;
  logic                    mem_enable_reg, mem_enable_next;

  logic bad_range;
  logic one_req;
  logic req_err;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  assign bad_range = |cpu.cpu_addr[CPU_ADDR_WIDTH-1:ADDR_SPACE];
`else
  // Upper address bits are deliberately dropped: the address wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu.cpu_addr[CPU_ADDR_WIDTH-1:ADDR_SPACE];
  assign bad_range      = 1'b0;
`endif

  assign one_req = cpu.rd_req ^ cpu.wr_req;
  assign req_err = (cpu.rd_req & cpu.wr_req) | (one_req & bad_range);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      ack_reg        <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
      mem_addr_reg   <= '0;
      mem_datain_reg <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_enable_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= busy_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
      mem_addr_reg   <= mem_addr_next;
      mem_datain_reg <= mem_datain_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      mem_enable_reg <= mem_enable_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_err)      state_next = DONE;
        else if (one_req) state_next = SETUP;
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = RELEASE;
      RELEASE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so every pin comes straight off a flop.
  always_comb begin
    busy_next       = (state_next != IDLE);
    ack_next        = (state_next == DONE);
    err_next        = (state_next == DONE) && (state_reg == IDLE);
    mem_enable_next = (state_next == STROBE);
    rdata_next      = rdata_reg;
    mem_addr_next   = mem_addr_reg;
    mem_datain_next = mem_datain_reg;
    mem_read_next   = mem_read_reg;
    mem_write_next  = mem_write_reg;

    if (state_reg == IDLE && state_next == SETUP) begin
      mem_addr_next   = cpu.cpu_addr[ADDR_SPACE-1:0];
      mem_datain_next = cpu.cpu_wdata;
      mem_read_next   = cpu.rd_req;
      mem_write_next  = cpu.wr_req;
    end

    // RAM drove dataout on the STROBE edge; it is settled by the end of RELEASE.
    if (state_reg == RELEASE && mem_read_reg) begin
      rdata_next = mem_dataout;
    end

    if (state_next == DONE) begin
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
    end
  end

  assign cpu.busy   = busy_reg;
  assign cpu.ack    = ack_reg;
  assign cpu.err    = err_reg;
  assign cpu.rdata  = rdata_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_datain = mem_datain_reg;
  assign mem_read   = mem_read_reg;
  assign mem_write  = mem_write_reg;
  assign mem_enable = mem_enable_reg;

endmodule
